pipe_sequencer: RTL and testbench

PIPE_SEQUENCER -- requirements
Module: pipe_sequencer

---
 rtl/pipe_sequencer.sv | 116 +++++++++++
 tb/tb_pipe_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_sequencer.sv
// Pipeline sequencer: IDLE/RUN/DRAIN/HALT control of PC, IF/ID and ID/EX latches.
// Enables and flushes are combinational from state and current ID/EX inputs (same cycle).
// Load-use stalls hold PC and IF/ID for exactly one cycle per hazard; taken branch flushes.
module pipe_sequencer #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   input  logic             id_is_halt,
   input  logic             ex_is_load,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_branch_taken,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             running,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALT} state_t;

   state_t     state;
   state_t     state_nxt;
   logic [1:0] drain_cnt;
   logic [1:0] drain_nxt;
   logic       stall_q;     // previous cycle was a load-use stall
   logic       hazard;
   logic       stall;

   // A load in EX feeding a source of the ID instruction; r0 never creates a dependency.
   assign hazard = ex_is_load && (ex_rd != '0) &&
                   ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

   // After one stall cycle the load has left EX, so a still-asserted hazard is stale.
   assign stall = (state == RUN) && !ex_branch_taken && hazard && !stall_q;

   // Next-state and latch-control decode; bubbles into ID/EX unless actively issuing.
   always_comb begin
      state_nxt   = state;
      drain_nxt   = drain_cnt;
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b1;
      running     = 1'b0;
      halted      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            running = 1'b1;
            if (ex_branch_taken) begin
               pc_en       = 1'b1;
               if_id_en    = 1'b1;
               if_id_flush = 1'b1;
            end else if (stall) begin
               pc_en    = 1'b0;
               if_id_en = 1'b0;
            end else if (id_is_halt) begin
               // HLT moves into EX; fetch freezes behind it.
               id_ex_flush = 1'b0;
               state_nxt   = DRAIN;
               drain_nxt   = 2'd3;
            end else begin
               pc_en       = 1'b1;
               if_id_en    = 1'b1;
               id_ex_flush = 1'b0;
            end
         end
         DRAIN: begin
            running = 1'b1;
            if (drain_cnt <= 2'd1) begin
               drain_nxt = 2'd0;
               state_nxt = HALT;
            end else begin
               drain_nxt = drain_cnt - 2'd1;
            end
         end
         HALT: begin
            halted = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, drain counter and stall history registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         drain_cnt <= 2'd0;
         stall_q   <= 1'b0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= drain_nxt;
         stall_q   <= stall;
      end
   end

   // Saturating count of load-use stall cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_pipe_sequencer.sv
// Bench for pipe_sequencer: spec-level model checked every cycle plus literal spot checks.
// Inputs change 1 time unit after the rising edge; outputs compared on the falling edge.
// Stall counter width reduced to 4 so saturation is reachable quickly.
module tb_pipe_sequencer;
   localparam int REG_W = 5;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [REG_W-1:0] id_rs = '0;
   logic [REG_W-1:0] id_rt = '0;
   logic             id_uses_rt = 1'b0;
   logic             id_is_halt = 1'b0;
   logic             ex_is_load = 1'b0;
   logic [REG_W-1:0] ex_rd = '0;
   logic             ex_branch_taken = 1'b0;
   logic             pc_en, if_id_en, if_id_flush, id_ex_flush, running, halted;
   logic [CNT_W-1:0] stall_cnt;

   int total = 0;
   int bad   = 0;
   bit check_en = 1'b0;

   pipe_sequencer #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_is_halt(id_is_halt),
      .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
      .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .running(running), .halted(halted), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // mode: 0 idle, 1 run, 2 drain, 3 halt
   int m_mode = 0;
   int m_drained = 0;       // DRAIN cycles already spent
   bit m_prev_stall = 0;
   int m_cnt = 0;

   function automatic bit haz_now();
      if (!ex_is_load || ex_rd == 0) return 0;
      if (ex_rd == id_rs) return 1;
      return id_uses_rt && (ex_rd == id_rt);
   endfunction

   function automatic bit stall_now();
      return (m_mode == 1) && !ex_branch_taken && haz_now() && !m_prev_stall;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = 0; m_drained = 0; m_prev_stall = 0; m_cnt = 0;
      end else begin
         bit s;
         s = stall_now();
         case (m_mode)
            0: if (start) m_mode = 1;
            1: begin
               if (s) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
               else if (!ex_branch_taken && id_is_halt) begin
                  m_mode = 2; m_drained = 0;
               end
            end
            2: begin
               m_drained++;
               if (m_drained == 3) m_mode = 3;
            end
            default: ;
         endcase
         m_prev_stall = s;
      end
   end

   // Compare every output against the model on each falling edge.
   always @(negedge clk) begin
      if (check_en) begin
         int e_pc, e_ifid, e_iff, e_idf;
         e_pc = 0; e_ifid = 0; e_iff = 0; e_idf = 1;
         if (m_mode == 1) begin
            if (ex_branch_taken) begin
               e_pc = 1; e_ifid = 1; e_iff = 1; e_idf = 1;
            end else if (stall_now()) begin
               e_idf = 1;
            end else if (id_is_halt) begin
               e_idf = 0;
            end else begin
               e_pc = 1; e_ifid = 1; e_idf = 0;
            end
         end
         chk("pc_en", pc_en, e_pc);
         chk("if_id_en", if_id_en, e_ifid);
         chk("if_id_flush", if_id_flush, e_iff);
         chk("id_ex_flush", id_ex_flush, e_idf);
         chk("running", running, (m_mode == 1 || m_mode == 2) ? 1 : 0);
         chk("halted", halted, (m_mode == 3) ? 1 : 0);
         chk("stall_cnt", stall_cnt, m_cnt);
      end
   end

   // ---------------- stimulus ----------------
   task automatic drv(input bit st, input int rs, input int rt, input bit urt,
                      input bit hlt, input bit ld, input int rd, input bit br);
      start = st; id_rs = rs[REG_W-1:0]; id_rt = rt[REG_W-1:0]; id_uses_rt = urt;
      id_is_halt = hlt; ex_is_load = ld; ex_rd = rd[REG_W-1:0]; ex_branch_taken = br;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      drv(0, 1, 2, 0, 0, 0, 0, 0);
   endtask

   initial begin
      idle_inputs();
      #3;
      chk("rst_pc_en", pc_en, 0);
      chk("rst_if_id_en", if_id_en, 0);
      chk("rst_if_id_flush", if_id_flush, 0);
      chk("rst_id_ex_flush", id_ex_flush, 1);
      chk("rst_running", running, 0);
      chk("rst_halted", halted, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      tick();
      rst_n = 1'b1;
      check_en = 1'b1;
      tick();
      chk("idle_wait_running", running, 0);

      // start pulse -> RUN
      drv(1, 1, 2, 0, 0, 0, 0, 0); tick();
      idle_inputs(); #2;
      chk("start_running", running, 1);
      chk("start_pc_en", pc_en, 1);
      chk("start_if_id_en", if_id_en, 1);
      chk("start_id_ex_flush", id_ex_flush, 0);

      // rs load-use hazard: one stall, counter 0 -> 1
      drv(0, 5, 2, 0, 0, 1, 5, 0); #2;
      chk("haz_pc_en", pc_en, 0);
      chk("haz_id_ex_flush", id_ex_flush, 1);
      tick();
      idle_inputs(); #2;
      chk("haz_stall_cnt", stall_cnt, 1);
      tick();
      // r0 destination never stalls
      drv(0, 0, 2, 0, 0, 1, 0, 0); #2;
      chk("r0_pc_en", pc_en, 1);
      tick();
      // rt hazard only when rt is used
      drv(0, 1, 7, 1, 0, 1, 7, 0); #2;
      chk("rt_haz_pc_en", pc_en, 0);
      tick();
      drv(0, 1, 7, 0, 0, 1, 7, 0); #2;
      chk("rt_unused_pc_en", pc_en, 1);
      tick();
      // hazard held for two cycles: only the first stalls
      drv(0, 9, 2, 0, 0, 1, 9, 0); tick();
      #2;
      chk("held_haz_second_pc_en", pc_en, 1);
      tick();
      idle_inputs(); #2;
      chk("held_haz_stall_cnt", stall_cnt, 3);

      // branch beats hazard, counter unchanged
      drv(0, 3, 2, 0, 0, 1, 3, 1); #2;
      chk("br_pc_en", pc_en, 1);
      chk("br_if_id_flush", if_id_flush, 1);
      chk("br_id_ex_flush", id_ex_flush, 1);
      tick();
      idle_inputs(); #2;
      chk("br_stall_cnt", stall_cnt, 3);

      // saturation
      for (int i = 0; i < 16; i++) begin
         drv(0, 4, 2, 0, 0, 1, 4, 0); tick();
         idle_inputs(); tick();
      end
      chk("sat_stall_cnt", stall_cnt, CMAX);

      // halt together with hazard: stall first, then HLT issues
      drv(0, 6, 2, 0, 1, 1, 6, 0); #2;
      chk("halt_haz_pc_en", pc_en, 0);
      chk("halt_haz_id_ex_flush", id_ex_flush, 1);
      tick(); #2;
      chk("halt_issue_id_ex_flush", id_ex_flush, 0);
      chk("halt_issue_pc_en", pc_en, 0);
      tick();
      // DRAIN: branch and start ignored
      drv(1, 1, 2, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         #2;
         chk("drain_running", running, 1);
         chk("drain_pc_en", pc_en, 0);
         chk("drain_halted", halted, 0);
         tick();
      end
      idle_inputs(); #2;
      chk("halt_halted", halted, 1);
      chk("halt_running", running, 0);
      drv(1, 1, 2, 0, 0, 0, 0, 0); tick();
      idle_inputs(); tick();
      chk("halt_start_ignored", halted, 1);

      // reset mid-DRAIN, asserted between edges
      #2 rst_n = 1'b0;
      #1;
      chk("rst_leave_halt", halted, 0);
      tick(); rst_n = 1'b1;
      drv(1, 1, 2, 0, 0, 0, 0, 0); tick();
      drv(0, 1, 2, 0, 1, 0, 0, 0); tick();
      idle_inputs(); tick();
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_running", running, 0);
      chk("mid_rst_pc_en", pc_en, 0);
      chk("mid_rst_if_id_flush", if_id_flush, 0);
      chk("mid_rst_id_ex_flush", id_ex_flush, 1);
      chk("mid_rst_stall_cnt", stall_cnt, 0);
      #1 rst_n = 1'b1;
      tick(); tick();
      chk("post_rst_idle_running", running, 0);
      chk("post_rst_halted", halted, 0);
      drv(1, 1, 2, 0, 0, 0, 0, 0); tick();
      idle_inputs(); #2;
      chk("restart_running", running, 1);
      tick();

      check_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
